// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive frame checker.
//   rx_chk_state_t : frame sequencer states
//   PAR_EVEN/ODD   : encodings of the par_type input
//   MAX_DATA_WIDTH : widest supported data field, sizes the bit counter
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_chk_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MAX_DATA_WIDTH = 9;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_err_counter.sv
// -----------------------------------------------------------------------------
// uart_rx_err_counter
// Saturating event counter for receive error statistics.
//   CLK : clock
//   RST : synchronous active-high reset
//   inc : count one event this cycle
//   clr : clear to zero; wins over a simultaneous inc
//   cnt : registered count, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module uart_rx_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable written in an always_comb gets a value on every
    // path (here the hold value first), otherwise synthesis infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order across blocks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : uart_rx_err_counter

// File: rtl/uart_rx_frame_check.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_check
// Sequences one UART frame (start, data, optional parity, 1-2 stop bits) from
// a stream of majority-voted bit samples and reports the result.
//   CLK, RST      : clock, synchronous active-high reset
//   bit_valid     : sampled_bit is valid this cycle
//   sampled_bit   : line value of the current bit
//   par_type      : 0 even / 1 odd, captured with the start bit
//   abort         : drop the current frame, back to IDLE, nothing reported
//   cnt_clr       : clear all error counters (wins over an increment)
//   data_out      : data of the last completed frame, first bit at bit 0
//   data_valid    : one-cycle pulse, frame ended without errors
//   frame_done    : one-cycle pulse on every frame end, false starts included
//   start_err, par_err, stop_err          : flags of the last ended frame
//   start_err_cnt, par_err_cnt, stop_err_cnt : saturating error counters
// -----------------------------------------------------------------------------
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_type,
    input  logic                  abort,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_done,
    output logic                  start_err,
    output logic                  par_err,
    output logic                  stop_err,
    output logic [CNT_W-1:0]      start_err_cnt,
    output logic [CNT_W-1:0]      par_err_cnt,
    output logic [CNT_W-1:0]      stop_err_cnt
);

    localparam int BCW = $clog2(MAX_DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    // Value of stop_cnt on the final stop bit (0 for one stop bit, 1 for two).
    localparam logic STOP_LAST = (STOP_BITS == 2);

    // Sequencer and datapath state
    rx_chk_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  par_acc_q, par_acc_d;
    logic                  par_type_q, par_type_d;
    logic                  par_err_acc_q, par_err_acc_d;
    logic                  stop_err_acc_q, stop_err_acc_d;

    // Registered outputs
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  start_err_q, start_err_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;

    // Counter increment requests and the final stop-error verdict
    logic start_inc, par_inc, stop_inc;
    logic stop_flag;

    // -------------------------------------------------------------------------
    // State register (all flops)
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            stop_cnt_q     <= 1'b0;
            par_acc_q      <= 1'b0;
            par_type_q     <= PAR_EVEN;
            par_err_acc_q  <= 1'b0;
            stop_err_acc_q <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            start_err_q    <= 1'b0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            stop_cnt_q     <= stop_cnt_d;
            par_acc_q      <= par_acc_d;
            par_type_q     <= par_type_d;
            par_err_acc_q  <= par_err_acc_d;
            stop_err_acc_q <= stop_err_acc_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            frame_done_q   <= frame_done_d;
            start_err_q    <= start_err_d;
            par_err_q      <= par_err_d;
            stop_err_q     <= stop_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (bit_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!sampled_bit) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    if (stop_cnt_q == STOP_LAST) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        stop_cnt_d     = stop_cnt_q;
        par_acc_d      = par_acc_q;
        par_type_d     = par_type_q;
        par_err_acc_d  = par_err_acc_q;
        stop_err_acc_d = stop_err_acc_q;
        data_out_d     = data_out_q;
        start_err_d    = start_err_q;
        par_err_d      = par_err_q;
        stop_err_d     = stop_err_q;
        data_valid_d   = 1'b0;
        frame_done_d   = 1'b0;
        start_inc      = 1'b0;
        par_inc        = 1'b0;
        stop_inc       = 1'b0;
        stop_flag      = stop_err_acc_q | ~sampled_bit;

        // An abort only redirects the sequencer; nothing reported is touched.
        if (!abort && bit_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!sampled_bit) begin
                        par_type_d     = par_type;
                        bit_cnt_d      = '0;
                        stop_cnt_d     = 1'b0;
                        par_acc_d      = 1'b0;
                        par_err_acc_d  = 1'b0;
                        stop_err_acc_d = 1'b0;
                    end else begin
                        // Line still high where a start bit was expected.
                        start_err_d  = 1'b1;
                        par_err_d    = 1'b0;
                        stop_err_d   = 1'b0;
                        frame_done_d = 1'b1;
                        start_inc    = 1'b1;
                    end
                end
                ST_DATA: begin
                    // Shift right so the first received bit lands at bit 0.
                    shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ sampled_bit;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_DATA) stop_cnt_d = 1'b0;
                end
                ST_PARITY: begin
                    // XOR of data and parity is 0 for even, 1 for odd parity.
                    par_err_acc_d = ((par_acc_q ^ sampled_bit) != par_type_q);
                    stop_cnt_d    = 1'b0;
                end
                ST_STOP: begin
                    stop_err_acc_d = stop_flag;
                    if (stop_cnt_q == STOP_LAST) begin
                        data_out_d   = shift_q;
                        start_err_d  = 1'b0;
                        par_err_d    = par_err_acc_q;
                        stop_err_d   = stop_flag;
                        frame_done_d = 1'b1;
                        data_valid_d = !par_err_acc_q && !stop_flag;
                        par_inc      = par_err_acc_q;
                        stop_inc     = stop_flag;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;
    assign start_err  = start_err_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;

    // -------------------------------------------------------------------------
    // Error counters
    // -------------------------------------------------------------------------
    uart_rx_err_counter #(.CNT_W(CNT_W)) u_start_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (start_inc),
        .clr (cnt_clr),
        .cnt (start_err_cnt)
    );

    uart_rx_err_counter #(.CNT_W(CNT_W)) u_par_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (par_inc),
        .clr (cnt_clr),
        .cnt (par_err_cnt)
    );

    uart_rx_err_counter #(.CNT_W(CNT_W)) u_stop_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stop_inc),
        .clr (cnt_clr),
        .cnt (stop_err_cnt)
    );

endmodule : uart_rx_frame_check

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised UART receive frame checker that supersedes the standalone start-bit check. It sits between the oversampling bit sampler and the RX output register. It consumes one sampled bit per strobe and sequences start, data, optional parity and 1–2 stop bits. It delivers the assembled data word, per-frame error flags and saturating error counters for status registers.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal range 5–9.
- `PARITY_EN`, default 1: 1 = a parity bit follows the data; 0 = no parity bit.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `CNT_W`, default 8: width of each error counter.
- `CLK` input, 1: single clock.
- `RST` input, 1: reset, synchronous and active-high.
- `bit_valid` input, 1: strobe; `sampled_bit` is valid this cycle.
- `sampled_bit` input, 1: majority-voted line value.
- `par_type` input, 1: 0 = even, 1 = odd. Latched when the start bit is accepted.
- `abort` input, 1: drop the frame in progress and return to IDLE.
- `cnt_clr` input, 1: clear all error counters.
- `data_out` output, DATA_WIDTH: last completed frame's data, LSB received first.
- `data_valid` output, 1: one-cycle pulse; frame completed with no errors.
- `frame_done` output, 1: one-cycle pulse on every frame end, including a false start.
- `start_err`, `par_err`, `stop_err` output, 1 each: error flags of the last ended frame.
- `start_err_cnt`, `par_err_cnt`, `stop_err_cnt` output, CNT_W each: saturating error counts.

## Operation
- **States:** IDLE, DATA, PARITY, STOP.
- **IDLE, on `bit_valid`:**
  - `sampled_bit`=0: accept the start bit. Latch `par_type`, clear `bit_cnt`, parity accumulator and the stop flag, go to DATA.
  - `sampled_bit`=1: false start. Set `start_err`=1, clear `par_err`/`stop_err`, pulse `frame_done`, increment `start_err_cnt`, stay in IDLE.
- **DATA, on `bit_valid`:** shift the bit into the MSB of the shift register (shift right, so the first bit ends at bit 0). XOR the bit into the parity accumulator and increment `bit_cnt`.
  - After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, else to STOP.
- **PARITY, on `bit_valid`:** the parity error is (accumulator XOR bit) != latched `par_type`. Go to STOP with `stop_cnt`=0.
- **STOP, on `bit_valid`:** `sampled_bit`=0 sets the stop-error flag. After STOP_BITS stop bits, end the frame and return to IDLE:
  - `data_out` <= shift register.
  - `start_err`=0, `par_err`/`stop_err` <= accumulated flags.
  - Pulse `frame_done`; pulse `data_valid` only if both flags are 0.
  - Increment the counters of the flags that are set.
  - `data_out` is updated even when the frame has errors.
- **Error flags:** hold their value until the next `frame_done`.
- **Counters:** saturate at 2^CNT_W-1 and do not wrap. `cnt_clr` has priority over an increment in the same cycle; the result is 0.
- **`abort`:** next state IDLE. No `frame_done`, counters unchanged, `data_out`/flags held.
- **Priority:** `RST` > `abort` > `bit_valid`.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters and shift register 0.
- All outputs are registered.
- `frame_done`, `data_valid`, flags, `data_out` and counters all update on the clock edge that samples the final `bit_valid` of a frame.
- `bit_valid` may be asserted on consecutive cycles. Cycles without `bit_valid` leave the state unchanged.
- `par_type` changes mid-frame have no effect on the current frame.
- `RST` mid-frame: IDLE next cycle, everything cleared.

## Structure
- Package `uart_rx_pkg`:
  - state enum `rx_chk_state_t`
  - constants `PAR_EVEN`=0 and `PAR_ODD`=1
  - `MAX_DATA_WIDTH`=9
- Sub-module `uart_rx_err_counter`: CNT_W saturating counter with `inc`/`clr`, clear priority. Instantiated three times.
- FSM, shift register and parity logic stay in the top module.

## Test plan
- **Clean frame:** defaults, even parity. Bits 0, then 1,0,1,0,0,1,0,1, then 0, then 1. Expect `data_out`=0xA5, `data_valid`=1, all flags 0, counters 0.
- **Parity error:** same frame with parity bit 1. Expect `data_out`=0xA5, `par_err`=1, `data_valid`=0, `par_err_cnt`=1. Repeat with `par_type`=1 and parity bit 1: no error.
- **False start:** `sampled_bit`=1 in IDLE. Expect `frame_done` and `start_err`=1, `start_err_cnt`=1, state stays IDLE. The next good frame clears `start_err`.
- **Two stop bits:** STOP_BITS=2, PARITY_EN=0, second stop bit 0. Expect `stop_err`=1 and `frame_done` only after the second stop bit.
- **Saturation and clear:** CNT_W=2, five stop errors. Expect `stop_err_cnt`=3. `cnt_clr` together with a sixth error gives 0.
- **Abort and reset mid-frame:** abort after 4 data bits gives no `frame_done`, then a full frame decodes correctly. `RST` mid-frame: all outputs 0 on the next cycle.
